// File: rtl/noc_buffer_vc.sv
// Multi-virtual-channel FWFT flit buffer: one independent {last, flit} FIFO per VC, shared input bus.
// Latency: a flit written at edge N is visible on out_* during cycle N+1 (no empty bypass).
// Backpressure: in_ready[c] deasserts when channel c holds DEPTH flits; out_ready[c] stalls the head.
// Optional macro NOC_BUFFER_VC_PACKET_MODE_EN: per-channel store-and-forward with cut-through on full.
module noc_buffer_vc #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [FLIT_WIDTH-1:0]                   in_flit,
    input  logic                                    in_last,
    input  logic [CHANNELS-1:0]                     in_valid,
    output logic [CHANNELS-1:0]                     in_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0]          out_flit,
    output logic [CHANNELS-1:0]                     out_last,
    output logic [CHANNELS-1:0]                     out_valid,
    input  logic [CHANNELS-1:0]                     out_ready,
    output logic [CHANNELS*$clog2(DEPTH+1)-1:0]     fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Only one channel may be written per cycle since they share in_flit.
    in_valid_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(in_valid));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [FLIT_WIDTH:0] mem [DEPTH];
        logic [AW-1:0]       rd_ptr;
        logic [AW-1:0]       wr_ptr;
        logic [CW-1:0]       count;
        logic                wr_en;
        logic                rd_en;

        // Ready comes from registered occupancy only, so no combinational path from out_ready.
        assign in_ready[c] = (count != CW'(DEPTH));
        assign wr_en       = in_valid[c] & in_ready[c];
        assign rd_en       = out_valid[c] & out_ready[c];

        assign {out_last[c], out_flit[c*FLIT_WIDTH +: FLIT_WIDTH]} = mem[rd_ptr];
        assign fill_level[c*CW +: CW] = count;

        // Storage array; contents are deliberately left unreset.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_ptr] <= {in_last, in_flit};
            end
        end

        // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                case ({wr_en, rd_en})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

`ifdef NOC_BUFFER_VC_PACKET_MODE_EN
        logic [CW-1:0] pkt_cnt;
        logic          draining;

        // Complete-packet count, plus a flag that keeps a partially read packet flowing.
        always_ff @(posedge clk) begin
            if (!rst) begin
                pkt_cnt  <= '0;
                draining <= 1'b0;
            end else begin
                case ({wr_en & in_last, rd_en & out_last[c]})
                    2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                    2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                    default: pkt_cnt <= pkt_cnt;
                endcase
                // Any non-last read means the rest of that packet must follow without waiting.
                if (rd_en) draining <= ~out_last[c];
            end
        end

        // Hold the head until a whole packet is in, except when full (oversized packet) or mid-packet.
        assign out_valid[c] = (count != '0) &
                              ((pkt_cnt != '0) | (count == CW'(DEPTH)) | draining);
`else
        assign out_valid[c] = (count != '0);
`endif
    end

endmodule

// File: tb/tb_noc_buffer_vc.sv
// Bench for noc_buffer_vc: directed scenarios plus random traffic against a queue-based model.
// Model tracks each channel as a queue of {last, flit}; packet mode adds a mid-packet flag.
// All checks are taken 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_noc_buffer_vc;
    localparam int FW = 32;
    localparam int CH = 2;
    localparam int D  = 16;
    localparam int CW = $clog2(D+1);

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     in_flit;
    logic              in_last;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [CH*FW-1:0]  out_flit;
    logic [CH-1:0]     out_last;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready;
    logic [CH*CW-1:0]  fill_level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FW:0] q [CH][$];
    bit          mid [CH];

    always #5 clk = ~clk;

    noc_buffer_vc #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .fill_level(fill_level)
    );

    function automatic logic [FW-1:0] head(int c);
        return out_flit[c*FW +: FW];
    endfunction

    function automatic logic [CW-1:0] fill(int c);
        return fill_level[c*CW +: CW];
    endfunction

    function automatic bit exp_valid(int c);
        if (q[c].size() == 0) return 1'b0;
`ifdef NOC_BUFFER_VC_PACKET_MODE_EN
        if (q[c].size() == D || mid[c]) return 1'b1;
        for (int i = 0; i < q[c].size(); i++) if (q[c][i][FW]) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    // Advance one clock and apply the accepted transfers to the model.
    task automatic tick();
        bit wr [CH];
        bit rd [CH];
        for (int c = 0; c < CH; c++) begin
            wr[c] = in_valid[c] && (q[c].size() < D);
            rd[c] = out_ready[c] && exp_valid(c);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (!rst) begin
                q[c].delete();
                mid[c] = 1'b0;
            end else begin
                if (rd[c]) begin
                    mid[c] = !q[c][0][FW];
                    void'(q[c].pop_front());
                end
                if (wr[c]) q[c].push_back({in_last, in_flit});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = '0; out_ready = '0; in_flit = '0; in_last = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (in_ready[c] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready ch%0d got %b want 1", c, in_ready[c]); end
            n_checks++;
            if (out_valid[c] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid ch%0d got %b want 0", c, out_valid[c]); end
            n_checks++;
            if (fill(c) !== '0) begin n_fail++; $display("FAIL reset_fill ch%0d got %0d want 0", c, fill(c)); end
        end
    endtask

    task automatic test_fill_drain();
        in_valid = 2'b01; out_ready = '0;
        for (int i = 0; i < D; i++) begin
            in_flit = FW'(i); in_last = (i == D-1);
            tick();
        end
        in_valid = '0;
        n_checks++;
        if (fill(0) !== CW'(D)) begin n_fail++; $display("FAIL full_fill got %0d want %0d", fill(0), D); end
        n_checks++;
        if (in_ready !== 2'b10) begin n_fail++; $display("FAIL full_in_ready got %b want 10", in_ready); end
        out_ready = 2'b01;
        for (int i = 0; i < D; i++) begin
            n_checks++;
            if (out_valid[0] !== 1'b1 || head(0) !== FW'(i)) begin
                n_fail++; $display("FAIL drain_data idx %0d got v=%b %h want v=1 %h", i, out_valid[0], head(0), i);
            end
            tick();
        end
        out_ready = '0;
        n_checks++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", out_valid[0]); end
    endtask

    task automatic test_back_to_back();
        in_valid = 2'b10; out_ready = 2'b10; in_last = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_flit = FW'(i);
            tick();
            n_checks++;
            if (fill(1) !== CW'(1) || out_valid[1] !== 1'b1 || head(1) !== FW'(i)) begin
                n_fail++; $display("FAIL stream idx %0d got fill=%0d v=%b %h want fill=1 v=1 %h", i, fill(1), out_valid[1], head(1), i);
            end
        end
        in_valid = '0;
        tick();
        out_ready = '0;
        n_checks++;
        if (fill(1) !== '0) begin n_fail++; $display("FAIL stream_end_fill got %0d want 0", fill(1)); end
    endtask

    task automatic test_full_simul();
        in_valid = 2'b01; out_ready = '0;
        for (int i = 0; i < D; i++) begin
            in_flit = FW'(32'h100 + i); in_last = (i == D-1);
            tick();
        end
        n_checks++;
        if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL simul_pre_ready got %b want 0", in_ready[0]); end
        in_flit = 32'hDEAD_BEEF; in_last = 1'b0; out_ready = 2'b01;
        tick();
        in_valid = '0; out_ready = '0;
        n_checks++;
        if (fill(0) !== CW'(D-1)) begin n_fail++; $display("FAIL simul_fill got %0d want %0d", fill(0), D-1); end
        n_checks++;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL simul_ready got %b want 1", in_ready[0]); end
        n_checks++;
        if (head(0) !== 32'h101) begin n_fail++; $display("FAIL simul_head got %h want 101", head(0)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 5) ? 2'b01 : 2'b10;
            in_flit = FW'($urandom); in_last = (i == 4 || i == 7);
            tick();
        end
        in_valid = '0; rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (fill(c) !== '0 || out_valid[c] !== 1'b0) begin
                n_fail++; $display("FAIL midreset ch%0d got fill=%0d v=%b want 0 0", c, fill(c), out_valid[c]);
            end
        end
        in_valid = 2'b01; in_flit = 32'hA5A5_A5A5; in_last = 1'b1;
        tick();
        in_valid = '0;
        n_checks++;
        if (out_valid[0] !== 1'b1 || head(0) !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL midreset_first got v=%b %h want v=1 a5a5a5a5", out_valid[0], head(0));
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, CH);
            in_valid  = (r == 0) ? '0 : CH'(1 << (r-1));
            in_flit   = FW'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = CH'($urandom);
            tick();
            for (int c = 0; c < CH; c++) begin
                n_checks++;
                if (fill(c) !== CW'(q[c].size()) || in_ready[c] !== (q[c].size() != D) || out_valid[c] !== exp_valid(c)) begin
                    n_fail++; $display("FAIL rand_state cyc %0d ch%0d got fill=%0d rdy=%b v=%b want fill=%0d v=%b",
                                       n, c, fill(c), in_ready[c], out_valid[c], q[c].size(), exp_valid(c));
                end
                if (q[c].size() != 0) begin
                    n_checks++;
                    if ({out_last[c], head(c)} !== q[c][0]) begin
                        n_fail++; $display("FAIL rand_head cyc %0d ch%0d got %h want %h", n, c, {out_last[c], head(c)}, q[c][0]);
                    end
                end
            end
        end
        in_valid = '0; out_ready = '0;
    endtask

`ifdef NOC_BUFFER_VC_PACKET_MODE_EN
    task automatic test_packet_small();
        do_reset();
        in_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            in_flit = FW'(32'h50 + i); in_last = (i == 2);
            tick();
            n_checks++;
            if (out_valid[0] !== (i == 2)) begin n_fail++; $display("FAIL pkt3_valid after write %0d got %b want %b", i, out_valid[0], i == 2); end
        end
        in_valid = '0; out_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid[0] !== 1'b1 || head(0) !== FW'(32'h50 + i)) begin
                n_fail++; $display("FAIL pkt3_drain idx %0d got v=%b %h want v=1 %h", i, out_valid[0], head(0), 32'h50 + i);
            end
            tick();
        end
        out_ready = '0;
    endtask

    task automatic test_packet_long();
        int wr_idx = 0;
        int rd_idx = 0;
        do_reset();
        in_valid = 2'b01;
        for (int i = 0; i < D; i++) begin
            in_flit = FW'(32'h200 + i); in_last = 1'b0;
            tick();
            wr_idx++;
            n_checks++;
            if (out_valid[0] !== (i == D-1)) begin n_fail++; $display("FAIL pkt20_hold after write %0d got %b want %b", i, out_valid[0], i == D-1); end
        end
        out_ready = 2'b01;
        for (int n = 0; n < 100 && rd_idx < 20; n++) begin
            in_valid = (wr_idx < 20) ? 2'b01 : 2'b00;
            in_flit  = FW'(32'h200 + wr_idx); in_last = (wr_idx == 19);
            if (out_valid[0]) begin
                n_checks++;
                if (head(0) !== FW'(32'h200 + rd_idx)) begin
                    n_fail++; $display("FAIL pkt20_order idx %0d got %h want %h", rd_idx, head(0), 32'h200 + rd_idx);
                end
                rd_idx++;
            end
            if (in_valid[0] && in_ready[0]) wr_idx++;
            tick();
        end
        n_checks++;
        if (rd_idx != 20) begin n_fail++; $display("FAIL pkt20_count got %0d want 20", rd_idx); end
        out_ready = '0; in_valid = 2'b01; in_flit = 32'h77; in_last = 1'b0;
        tick();
        in_valid = '0;
        n_checks++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL pkt_cnt_zero got v=%b want 0", out_valid[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_simul();
        test_reset_mid();
        test_random();
`ifdef NOC_BUFFER_VC_PACKET_MODE_EN
        test_packet_small();
        test_packet_long();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/noc_buffer_vc.md
Name: noc_buffer_vc

Overview:
- Multi-virtual-channel synchronous FWFT flit buffer for NoC links.
- Next generation of the single-channel NoC FIFO wrapper: one independent FIFO per virtual channel sharing one input flit bus, with a `last` flag carried per flit and per-channel fill level.
- Sits at router input ports and network adapter ingress/egress.
- With the optional feature, acts as a store-and-forward packet buffer.

Parameters:
- FLIT_WIDTH, 32, payload bits per flit (excluding `last`).
- CHANNELS, 2, number of virtual channels, ≥1.
- DEPTH, 16, flits per channel, power of 2, ≥2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- in_flit  in  FLIT_WIDTH  input flit, shared by all channels
- in_last  in  1  input flit is last of packet
- in_valid  in  CHANNELS  per-channel write request, at most one bit set
- in_ready  out  CHANNELS  per-channel space available
- out_flit  out  CHANNELS*FLIT_WIDTH  head flit per channel; channel c at [c*FLIT_WIDTH +: FLIT_WIDTH]
- out_last  out  CHANNELS  head flit `last` per channel
- out_valid  out  CHANNELS  head flit valid per channel
- out_ready  in  CHANNELS  per-channel read accept
- fill_level  out  CHANNELS*$clog2(DEPTH+1)  registered occupancy per channel

Behaviour:
- Per-channel storage: DEPTH entries of {last, flit}, read pointer, write pointer, registered count.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - Count range is 0..DEPTH.
- Reset (rst=0 at clk edge), all channels:
  - pointers = 0, count = 0
  - in_ready = all 1s, out_valid = 0, fill_level = 0
  - out_flit/out_last: don't care.
  - Storage contents are not reset.
  - Reset asserted mid-packet discards all buffered flits. No partial state survives.
- Write to channel c: in_valid[c] & in_ready[c] at clk edge. Stores {in_last, in_flit} at wr_ptr[c] and increments wr_ptr[c].
- Read from channel c: out_valid[c] & out_ready[c] at clk edge. Increments rd_ptr[c].
- in_ready[c] = (count[c] != DEPTH). Depends only on registered state, never combinationally on in_valid or out_ready.
- FWFT output:
  - out_flit[c]/out_last[c] are the entry at rd_ptr[c], read combinationally from storage.
  - out_valid[c] = (count[c] != 0) in base mode.
- Latency: a flit written at edge N appears at the output during cycle N+1. No empty-bypass path.
- Simultaneous read and write on the same channel: both occur and count is unchanged. This is legal for 0<count<DEPTH.
  - count==DEPTH: in_ready=0, so only the read occurs. Space is visible next cycle.
  - count==0: out_valid=0, so only the write occurs.
- Channels are fully independent. Reads on several channels in one cycle are allowed.
- in_valid with more than one bit set is illegal. The simulation-only assertion fires an error.
- fill_level[c] = count[c] after the edge.
- in_last is stored as-is. In base mode, packet framing is not interpreted.

Optional Feature:
- Macro: NOC_BUFFER_VC_PACKET_MODE_EN
- Defined: store-and-forward per channel.
  - Each channel keeps a packet counter pkt_cnt[c], width $clog2(DEPTH+1), reset 0.
  - Increments on an accepted write with in_last=1.
  - Decrements on an accepted read with out_last=1.
  - Both events in one cycle leave it unchanged.
  - out_valid[c] = (count[c]!=0) & ((pkt_cnt[c]!=0) | (count[c]==DEPTH)).
  - The full-with-no-complete-packet case releases flits cut-through to avoid deadlock on packets longer than DEPTH.
  - Once the first flit of such a packet is released, out_valid stays asserted for the rest of that packet while count!=0. A per-channel `draining` flag, reset 0, cleared on the read of the `last` flit, implements this.
- Undefined: pkt_cnt and draining are not built. out_valid[c] = (count[c]!=0).

Test Plan:
- Reset then idle:
  - in_ready=all 1s, out_valid=0, fill_level=0 for all channels.
- Write 16 flits 0x00000000..0x0000000F to ch0, out_ready=0, DEPTH=16:
  - fill_level[ch0]=16 and in_ready[0]=0 after the 16th edge.
  - ch1 in_ready stays 1.
  - Drain: data in order 0x0..0xF, out_valid[0] drops after the 16th read.
- Continuous write plus read on ch1 for 40 cycles, values 0..39:
  - Output sequence 0..39 with no loss or duplication.
  - Pointers wrap twice. fill_level stays at 1 after the first cycle.
- Full ch0 with in_valid[0]=1 and out_ready[0]=1 in the same cycle:
  - Only the read happens, fill_level=15.
  - Next cycle in_ready[0]=1.
- Assert rst=0 for one cycle with 5 flits buffered in ch0 and 3 in ch1:
  - All fill_level=0 and out_valid=0 next cycle.
  - A new flit 0xA5A5A5A5 written afterwards is the first flit read.
- With NOC_BUFFER_VC_PACKET_MODE_EN:
  - 3-flit packet (last on the 3rd) to ch0: out_valid[0]=0 until the cycle after the 3rd write.
  - 20-flit packet, DEPTH=16: out_valid rises at count=16 and the full packet drains in order.
  - pkt_cnt returns to 0.
